// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads, queues {word, pc} for decode; FETCH_ALIGN_CHECK_EN traps misaligned redirects.
// Response->inst_valid one cycle; requests stall on queue+in-flight credits, decode stalls hold the queue head.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic {RUN, FAULT} state_t;
`else
    typedef enum logic {RUN} state_t;
`endif

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          hold_q, hold_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   ipc_q  [DEPTH];

    logic          fire, pop, push, resp_drop;
    logic [CW-1:0] fire_e, resp_e, pop_e, push_e;
    logic [CW:0]   credit_used;
    logic [31:0]   resp_pc;

    assign inst_valid  = (count_q != '0);
    assign instruction = word_q[rd_ptr_q];
    assign inst_pc     = ipc_q[rd_ptr_q];
    assign imem_addr   = pc_q;

    always_comb begin
        pop         = inst_valid && inst_ready;
        // A slot freed by this cycle's pop can be reused, which is what sustains
        // one instruction per cycle at DEPTH=2; once raised, the request is held
        // until accepted so imem_addr never changes under a pending request.
        credit_used = {1'b0, count_q} + {1'b0, inflight_q} - {{CW{1'b0}}, pop};
        imem_req_valid = !reset && (state_q == RUN) && !redirect_valid &&
                         (hold_q || (credit_used < DEPTH_C));
        fire        = imem_req_valid && imem_req_ready;
        resp_drop   = (drop_q != '0);
        push        = imem_resp_valid && !resp_drop && !redirect_valid;
        // Live requests are the newest ones, contiguous up to pc_q-4.
        resp_pc     = pc_q - (32'(inflight_q) << 2);

        fire_e = {{(CW-1){1'b0}}, fire};
        resp_e = {{(CW-1){1'b0}}, imem_resp_valid};
        pop_e  = {{(CW-1){1'b0}}, pop};
        push_e = {{(CW-1){1'b0}}, push};

        pc_d       = fire ? pc_q + 32'd4 : pc_q;
        inflight_d = inflight_q + fire_e - resp_e;
        drop_d     = (imem_resp_valid && resp_drop) ? drop_q - ONE_C : drop_q;
        count_d    = count_q + push_e - pop_e;
        rd_ptr_d   = pop  ? rd_ptr_q + PONE_C : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PONE_C : wr_ptr_q;
        hold_d     = imem_req_valid && !imem_req_ready;
        state_d    = state_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            drop_d   = inflight_q - resp_e;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
`ifdef FETCH_ALIGN_CHECK_EN
            state_d  = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`else
            state_d  = RUN;
`endif
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            hold_q     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            hold_q     <= hold_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q    <= (state_d == FAULT);
`endif
            if (push) begin
                word_q[wr_ptr_q] <= imem_resp_data;
                ipc_q[wr_ptr_q]  <= resp_pc;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: randomized memory timing and handshakes against a PC-stream reference model.
module tb_instruction_fetch;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    instruction_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // memory model state
    logic [31:0] key;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc, lat, last_due;
    bit          rand_lat;
    int          req_pct, inst_pct;

    // reference model: expected delivered / requested PC streams
    logic [31:0] exp_pc, exp_req;
    bit          faulted, prev_redir;
    bit          redir_go;
    logic [31:0] redir_to;
    int          deliv_since, acc_since, delivered, accepted;
    logic [31:0] first_pc, second_pc;
    int          deliv_cyc[$];

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ key;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step();
        int d;
        @(negedge clk);
        cyc++;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend_addr.size() > 0 && pend_due[0] == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memword(pend_addr[0]);
            pend_addr.delete(0);
            pend_due.delete(0);
        end
        imem_req_ready = ($urandom_range(99) < req_pct);
        inst_ready     = ($urandom_range(99) < inst_pct);
        redirect_valid = redir_go;
        redirect_pc    = redir_go ? redir_to : $urandom();
        redir_go       = 1'b0;
        #1;
        chk1("fault_flag", fetch_fault, faulted);
        if (prev_redir) chk1("cleared_after_redirect", inst_valid, 1'b0);
        if (faulted || redirect_valid) chk1("no_request", imem_req_valid, 1'b0);
        if (inst_valid && inst_ready) begin
            chk32("inst_pc", inst_pc, exp_pc);
            chk32("instruction", instruction, memword(exp_pc));
            if (deliv_since == 0) first_pc = inst_pc;
            else if (deliv_since == 1) second_pc = inst_pc;
            deliv_since++;
            delivered++;
            deliv_cyc.push_back(cyc);
            exp_pc += 32'd4;
        end
        if (imem_req_valid && imem_req_ready) begin
            chk32("imem_addr", imem_addr, exp_req);
            d = cyc + (rand_lat ? int'($urandom_range(3, 1)) : lat);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend_addr.push_back(imem_addr);
            pend_due.push_back(d);
            chk1("credit_cap", pend_addr.size() <= DEPTH, 1'b1);
            exp_req += 32'd4;
            acc_since++;
            accepted++;
        end
        if (redirect_valid) begin
            exp_pc      = redirect_pc & 32'hFFFF_FFFC;
            exp_req     = redirect_pc & 32'hFFFF_FFFC;
            deliv_since = 0;
            acc_since   = 0;
            first_pc    = 32'hDEAD_BEEF;
            second_pc   = 32'hDEAD_BEEF;
`ifdef FETCH_ALIGN_CHECK_EN
            faulted = (redirect_pc[1:0] != 2'b00);
`else
            faulted = 1'b0;
`endif
        end
        prev_redir = redirect_valid;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_pct  = 0;
        inst_pct = 100;
        while (pend_addr.size() != 0 && n < 30) begin
            step();
            n++;
        end
        chk1("drain", pend_addr.size() == 0, 1'b1);
    endtask

    initial begin
        int acc_before;
        key = $urandom();
        reset = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        cyc = -1; lat = 1; last_due = -1; rand_lat = 1'b0;
        req_pct = 100; inst_pct = 100;
        exp_pc = 32'h100; exp_req = 32'h100;
        faulted = 1'b0; prev_redir = 1'b0; redir_go = 1'b0; redir_to = '0;
        deliv_since = 0; acc_since = 0; delivered = 0; accepted = 0;
        first_pc = 32'hDEAD_BEEF; second_pc = 32'hDEAD_BEEF;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk32("rst_imem_addr", imem_addr, 32'h100);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_instruction", instruction, 32'h0);
        chk32("rst_inst_pc", inst_pc, 32'h0);
        chk1("rst_fetch_fault", fetch_fault, 1'b0);

        // reset fetch: first request in cycle 0, deliveries in cycles 2,3,4
        @(posedge clk);
        #2 reset = 1'b0;
        step();
        chk1("first_req", imem_req_valid, 1'b1);
        repeat (5) step();
        chk1("reset_fetch_count", deliv_cyc.size() >= 3, 1'b1);
        if (deliv_cyc.size() >= 3) begin
            chk32("deliv0_cycle", 32'(deliv_cyc[0]), 32'd2);
            chk32("deliv1_cycle", 32'(deliv_cyc[1]), 32'd3);
            chk32("deliv2_cycle", 32'(deliv_cyc[2]), 32'd4);
        end

        // backpressure: exactly DEPTH requests while decode stalls
        inst_pct = 0;
        redir_go = 1'b1; redir_to = 32'h400;
        step();
        repeat (8) step();
        chk32("bp_accepted", 32'(acc_since), 32'(DEPTH));
        chk1("bp_req_low", imem_req_valid, 1'b0);
        chk1("bp_head_valid", inst_valid, 1'b1);
        chk32("bp_head_pc", inst_pc, 32'h400);
        inst_pct = 100;
        repeat (6) step();
        chk32("bp_first", first_pc, 32'h400);
        chk32("bp_second", second_pc, 32'h404);
        chk1("bp_flow", deliv_since >= 4, 1'b1);

        // redirect with two requests in flight, 3-cycle memory
        drain();
        lat = 3; req_pct = 100; inst_pct = 100;
        redir_go = 1'b1; redir_to = 32'h1000;
        step();
        repeat (2) step();
        chk32("two_inflight", 32'(acc_since), 32'd2);
        redir_go = 1'b1; redir_to = 32'h200;
        step();
        repeat (12) step();
        chk1("rd2_delivered", deliv_since >= 1, 1'b1);
        chk32("rd2_first_pc", first_pc, 32'h200);

        // redirect coinciding with a response, 2-cycle memory
        drain();
        lat = 2; req_pct = 100; inst_pct = 100;
        redir_go = 1'b1; redir_to = 32'h500;
        step();
        repeat (2) step();
        redir_go = 1'b1; redir_to = 32'h600;
        step();
        repeat (10) step();
        chk1("rr_delivered", deliv_since >= 1, 1'b1);
        chk32("rr_first_pc", first_pc, 32'h600);

        // PC wrap
        redir_go = 1'b1; redir_to = 32'hFFFF_FFFC;
        step();
        repeat (10) step();
        chk32("wrap_first", first_pc, 32'hFFFF_FFFC);
        chk32("wrap_second", second_pc, 32'h0000_0000);

        // misaligned redirect
        drain();
        lat = 1; req_pct = 100; inst_pct = 100;
        redir_go = 1'b1; redir_to = 32'h202;
        step();
`ifdef FETCH_ALIGN_CHECK_EN
        repeat (5) step();
        chk1("fault_set", fetch_fault, 1'b1);
        chk32("fault_no_accept", 32'(acc_since), 32'd0);
        chk1("fault_no_inst", inst_valid, 1'b0);
        redir_go = 1'b1; redir_to = 32'h300;
        step();
        repeat (6) step();
        chk1("fault_clear", fetch_fault, 1'b0);
        chk32("fault_resume_pc", first_pc, 32'h300);
`else
        repeat (6) step();
        chk1("mis_no_fault", fetch_fault, 1'b0);
        chk32("mis_first_pc", first_pc, 32'h200);
`endif

        // redirect every cycle
        acc_before = accepted;
        for (int i = 0; i < 6; i++) begin
            redir_go = 1'b1;
            redir_to = $urandom() & 32'hFFFF_FFFC;
            step();
        end
        chk32("redir_storm_accepts", 32'(accepted - acc_before), 32'd0);
        chk1("redir_storm_inst", inst_valid, 1'b0);

        // randomized traffic
        rand_lat = 1'b1; req_pct = 70; inst_pct = 60;
        acc_before = delivered;
        for (int i = 0; i < 400; i++) begin
            redir_go = ($urandom_range(99) < 4);
`ifdef FETCH_ALIGN_CHECK_EN
            redir_to = $urandom() & 32'hFFFF_FFFC;
`else
            redir_to = $urandom();
`endif
            step();
        end
        drain();
        chk1("random_progress", (delivered - acc_before) > 50, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of `Decode`. It owns the program counter, issues word reads to instruction memory through a valid/ready request port, and buffers returned words in a small in-order queue. It presents `{instruction, pc}` to decode with a valid/ready handshake and restarts fetch at a new PC on a redirect from execute.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `DEPTH`, 2, instruction queue entries; power of two, 2..8; also the cap on queued plus in-flight fetches.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_addr` out 32: fetch byte address; bits [1:0] are always 0.
- `imem_resp_valid` in 1: read data returned this cycle.
- `imem_resp_data` in 32: instruction word.
- `redirect_valid` in 1: restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new PC.
- `inst_valid` out 1: queue head valid.
- `inst_ready` in 1: decode consumes the head.
- `instruction` out 32: head instruction word.
- `inst_pc` out 32: PC of the head instruction.
- `fetch_fault` out 1: misaligned redirect trapped. Present only with `FETCH_ALIGN_CHECK_EN`; otherwise tied 0.

## Operation
- Registers:
  - `pc`: next address to request.
  - `inflight`: accepted requests with no response yet, 0..DEPTH.
  - `drop`: stale responses still to discard.
  - Queue: DEPTH entries of `{word, pc}`, with read/write pointers and a count.
- States:
  - RUN: normal fetching.
  - FAULT: entered only under the configuration macro.
- Request rule: `imem_req_valid = (state==RUN) && !redirect_valid && (count + inflight < DEPTH)`, with `imem_addr = pc`.
- On `imem_req_valid && imem_req_ready`: `pc += 4` (wraps modulo 2^32) and `inflight++`.
- Memory contract:
  - Responses arrive in order, at least 1 cycle after acceptance.
  - Memory never stalls responses.
  - The credit rule guarantees queue space for every response.
- On `imem_resp_valid`:
  - `inflight--`.
  - If `drop != 0`: `drop--` and discard the word.
  - Otherwise push `{imem_resp_data, pc_of_request}`. A per-request PC FIFO, or `pc - 4*(count_pending)`, supplies the PC; the implementation chooses which.
- Pop on `inst_valid && inst_ready`.
- Redirect (highest priority), in the cycle `redirect_valid` is high:
  - Next `pc = {redirect_pc[31:2], 2'b00}`.
  - Queue is cleared.
  - Next `drop` = in-flight requests not answered this cycle.
  - No request is issued.
- A request held but not yet accepted may be withdrawn only by a redirect. Otherwise `imem_addr` is stable until accepted.

## Timing
- Reset values:
  - `imem_req_valid` 0, `imem_addr` RESET_PC.
  - `inst_valid` 0, `instruction` 0, `inst_pc` 0.
  - `fetch_fault` 0, state RUN, `inflight` 0, `drop` 0, queue empty.
- First request is asserted in the first cycle after `reset` deasserts.
- Response in cycle N → `inst_valid` in cycle N+1, with queue outputs registered. There is no same-cycle fall-through.
- Throughput: with 1-cycle memory and `inst_ready` held high, sustain 1 instruction/cycle when DEPTH ≥ 2.
- Full queue with pop and push in the same cycle: both occur, count unchanged.
- Redirect coinciding with a response: that response is discarded, and `drop` excludes it.
- Redirect coinciding with a decode handshake: the handshake completes, then the queue empties.
- Redirect every cycle: no requests issue, and `inst_valid` stays 0 after the first.
- `reset` mid-operation: all state clears immediately, asynchronously. Any later memory response for a pre-reset request is the environment's responsibility; the bench must not send one.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` enters FAULT and sets `fetch_fault` = 1 from the next cycle.
  - In FAULT, no requests issue and the queue is cleared as for any redirect.
  - The next aligned redirect returns to RUN and clears `fetch_fault`.
- Not defined: `redirect_pc[1:0]` is silently zeroed, there is no FAULT state, and `fetch_fault` = 0.

## Test plan
- **Reset fetch:** RESET_PC=0x100, 1-cycle memory, `inst_ready`=1 → instructions at `inst_pc` 0x100, 0x104, 0x108 on consecutive cycles, starting 2 cycles after reset release.
- **Backpressure:** DEPTH=2, `inst_ready`=0 → exactly 2 requests accepted, `imem_req_valid`=0 thereafter. Raise `inst_ready` → words delivered in order with no loss or duplication.
- **Redirect with 2 in flight** (3-cycle memory): redirect to 0x200 → both old responses dropped. First delivered `inst_pc`=0x200, with its word matching memory[0x200].
- **Redirect + response same cycle:** the response is discarded and `drop` counts only the remaining in-flight request. Next instruction is from `redirect_pc`.
- **PC wrap:** redirect to 0xFFFF_FFFC → delivered PCs 0xFFFF_FFFC, 0x0000_0000.
- **Macro on:** redirect to 0x202 → `fetch_fault`=1 and no requests. Redirect to 0x300 → `fetch_fault`=0 and fetching resumes at 0x300. **Macro off:** 0x202 fetches from 0x200.
